// File: rtl/div_pkg.sv
// Shared types and helpers for the divider-result BCD converter.
package div_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  // Decimal digit count of the largest unsigned value of the given width.
  function automatic int dec_digits(input int width);
    longint unsigned v;
    int d;
    v = (64'd1 << width) - 64'd1;
    d = 1;
    while (v >= 64'd10) begin
      v = v / 64'd10;
      d++;
    end
    return d;
  endfunction

endpackage

// File: rtl/bcd_digit_adj.sv
// Double-dabble nibble correction: add 3 to a BCD digit that is 5 or more.
module bcd_digit_adj (
  input  logic [3:0] i_nib,
  output logic [3:0] o_nib
);

  assign o_nib = (i_nib >= 4'd5) ? (i_nib + 4'd3) : i_nib;

endmodule

// File: rtl/div_bcd_convert.sv
// Converts a divider's quotient/remainder to packed BCD with a shared shift-add FSM.
// Handshakes: a transfer happens on a rising clk edge where valid && ready are both 1.
module div_bcd_convert
  import div_pkg::*;
#(
  parameter  int DIVIDEND = 3,
  parameter  int DIVISOR  = 2,
  localparam int QD       = dec_digits(DIVIDEND),
  localparam int RD       = dec_digits(DIVISOR)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [DIVIDEND-1:0] quotient,
  input  logic [DIVISOR-1:0]  remainder,
  input  logic                div_zero,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [4*QD-1:0]     quo_bcd,
  output logic [4*RD-1:0]     rem_bcd,
  output logic                out_err,
  output state_t              dbg_state
);

  localparam int N  = (DIVIDEND > DIVISOR) ? DIVIDEND : DIVISOR;
  localparam int CW = $clog2(N) + 1;

  state_t          r_state;
  logic [CW-1:0]   r_cnt;
  logic [N-1:0]    r_qsh;
  logic [N-1:0]    r_rsh;
  logic [4*QD-1:0] r_qacc;
  logic [4*RD-1:0] r_racc;
  logic [4*QD-1:0] r_quo_bcd;
  logic [4*RD-1:0] r_rem_bcd;
  logic            r_err;
  logic            r_out_valid;

  logic [4*QD-1:0] w_qadj;
  logic [4*RD-1:0] w_radj;
  logic [4*QD-1:0] w_qnext;
  logic [4*RD-1:0] w_rnext;

  for (genvar g = 0; g < QD; g++) begin : g_qadj
    bcd_digit_adj u_adj (.i_nib(r_qacc[4*g +: 4]), .o_nib(w_qadj[4*g +: 4]));
  end

  for (genvar g = 0; g < RD; g++) begin : g_radj
    bcd_digit_adj u_adj (.i_nib(r_racc[4*g +: 4]), .o_nib(w_radj[4*g +: 4]));
  end

  // The bit shifted out of the top digit is always zero because QD/RD digits hold the full range.
  assign w_qnext = (w_qadj << 1) | (4*QD)'(r_qsh[N-1]);
  assign w_rnext = (w_radj << 1) | (4*RD)'(r_rsh[N-1]);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_qsh       <= '0;
      r_rsh       <= '0;
      r_qacc      <= '0;
      r_racc      <= '0;
      r_quo_bcd   <= '0;
      r_rem_bcd   <= '0;
      r_err       <= 1'b0;
      r_out_valid <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            if (div_zero) begin
              r_quo_bcd   <= '1;
              r_rem_bcd   <= '1;
              r_err       <= 1'b1;
              r_out_valid <= 1'b1;
              r_state     <= DONE;
            end else begin
              r_qsh   <= N'(quotient);
              r_rsh   <= N'(remainder);
              r_qacc  <= '0;
              r_racc  <= '0;
              r_cnt   <= '0;
              r_state <= SHIFT;
            end
          end
        end
        SHIFT: begin
          r_qacc <= w_qnext;
          r_racc <= w_rnext;
          r_qsh  <= r_qsh << 1;
          r_rsh  <= r_rsh << 1;
          r_cnt  <= r_cnt + CW'(1);
          if (r_cnt == CW'(N - 1)) begin
            r_quo_bcd   <= w_qnext;
            r_rem_bcd   <= w_rnext;
            r_err       <= 1'b0;
            r_out_valid <= 1'b1;
            r_state     <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_state     <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign in_ready  = (r_state == IDLE);
  assign out_valid = r_out_valid;
  assign quo_bcd   = r_quo_bcd;
  assign rem_bcd   = r_rem_bcd;
  assign out_err   = r_err;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_div_bcd_convert.sv
// Bench for div_bcd_convert: default-width instance (a) and an 8/4-bit instance (b),
// checked every cycle against a decimal-arithmetic model plus literal expectations.
module tb_div_bcd_convert;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_a = 1'b1, rst_b = 1'b1;
  logic       iv_a = 0, dz_a = 0, or_a = 0, ir_a, ov_a, err_a;
  logic [2:0] q_a = '0;
  logic [1:0] r_a = '0;
  logic [3:0] qb_a, rb_a;
  logic [1:0] st_a;
  logic       iv_b = 0, dz_b = 0, or_b = 0, ir_b, ov_b, err_b;
  logic [7:0] q_b = '0;
  logic [3:0] r_b = '0;
  logic [11:0] qb_b;
  logic [7:0]  rb_b;
  logic [1:0]  st_b;

  div_bcd_convert u_a (
    .clk(clk), .reset(rst_a), .in_valid(iv_a), .in_ready(ir_a),
    .quotient(q_a), .remainder(r_a), .div_zero(dz_a),
    .out_valid(ov_a), .out_ready(or_a), .quo_bcd(qb_a), .rem_bcd(rb_a),
    .out_err(err_a), .dbg_state(st_a)
  );

  div_bcd_convert #(.DIVIDEND(8), .DIVISOR(4)) u_b (
    .clk(clk), .reset(rst_b), .in_valid(iv_b), .in_ready(ir_b),
    .quotient(q_b), .remainder(r_b), .div_zero(dz_b),
    .out_valid(ov_b), .out_ready(or_b), .quo_bcd(qb_b), .rem_bcd(rb_b),
    .out_err(err_b), .dbg_state(st_b)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: conversion delay in edges and digit counts for each instance.
  int nbits [2] = '{3, 8};
  int qdig  [2] = '{1, 3};
  int rdig  [2] = '{1, 2};

  bit          m_idle [2];
  bit          m_vld  [2];
  bit          m_err  [2];
  int          m_wait [2];
  logic [31:0] m_quo  [2];
  logic [31:0] m_rem  [2];
  logic [31:0] p_quo  [2];
  logic [31:0] p_rem  [2];

  function automatic logic [31:0] to_bcd(input int v, input int digits);
    logic [31:0] res;
    res = '0;
    for (int i = 0; i < digits; i++) begin
      res = res | (32'(v % 10) << (4 * i));
      v = v / 10;
    end
    return res;
  endfunction

  task automatic model_step(input int d, input logic rst, input logic vld, input int q,
                            input int r, input logic z, input logic ordy);
    if (rst) begin
      m_idle[d] = 1; m_vld[d] = 0; m_err[d] = 0; m_wait[d] = 0;
      m_quo[d] = '0; m_rem[d] = '0;
    end else if (m_vld[d]) begin
      if (ordy) begin
        m_vld[d] = 0; m_idle[d] = 1;
      end
    end else if (m_wait[d] > 0) begin
      m_wait[d]--;
      if (m_wait[d] == 0) begin
        m_vld[d] = 1; m_err[d] = 0; m_quo[d] = p_quo[d]; m_rem[d] = p_rem[d];
      end
    end else if (m_idle[d] && vld) begin
      m_idle[d] = 0;
      if (z) begin
        m_vld[d] = 1; m_err[d] = 1;
        m_quo[d] = 32'((1 << (4 * qdig[d])) - 1);
        m_rem[d] = 32'((1 << (4 * rdig[d])) - 1);
      end else begin
        p_quo[d] = to_bcd(q, qdig[d]);
        p_rem[d] = to_bcd(r, rdig[d]);
        m_wait[d] = nbits[d];
      end
    end
  endtask

  always @(posedge clk) begin
    model_step(0, rst_a, iv_a, int'(q_a), int'(r_a), dz_a, or_a);
    model_step(1, rst_b, iv_b, int'(q_b), int'(r_b), dz_b, or_b);
    #1;
    chk("a_in_ready",  32'(ir_a),  32'(m_idle[0]));
    chk("a_out_valid", 32'(ov_a),  32'(m_vld[0]));
    chk("a_out_err",   32'(err_a), 32'(m_err[0]));
    chk("a_quo_bcd",   32'(qb_a),  m_quo[0]);
    chk("a_rem_bcd",   32'(rb_a),  m_rem[0]);
    chk("b_in_ready",  32'(ir_b),  32'(m_idle[1]));
    chk("b_out_valid", 32'(ov_b),  32'(m_vld[1]));
    chk("b_out_err",   32'(err_b), 32'(m_err[1]));
    chk("b_quo_bcd",   32'(qb_b),  m_quo[1]);
    chk("b_rem_bcd",   32'(rb_b),  m_rem[1]);
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Present one result, keep in_valid high with junk while busy, then handshake after 'hold' cycles.
  task automatic xfer_a(input logic [2:0] q, input logic [1:0] r, input logic z, input int hold,
                        input bit lit, input logic [3:0] lq, input logic [3:0] lr, input int llat);
    int lat;
    iv_a = 1; q_a = q; r_a = r; dz_a = z; or_a = 0;
    tick;
    q_a = ~q; r_a = ~r; dz_a = ~z;
    lat = 1;
    while (!ov_a && lat < 40) begin
      tick;
      lat++;
    end
    chk("a_valid_seen", 32'(ov_a), 32'd1);
    if (lit) begin
      chk("a_latency", 32'(lat), 32'(llat));
      chk("a_quo_lit", 32'(qb_a), 32'(lq));
      chk("a_rem_lit", 32'(rb_a), 32'(lr));
      chk("a_err_lit", 32'(err_a), 32'(z));
    end
    repeat (hold) tick;
    or_a = 1;
    tick;
    iv_a = 0; or_a = 0;
  endtask

  task automatic xfer_b(input logic [7:0] q, input logic [3:0] r, input logic z, input int hold,
                        input bit lit, input logic [11:0] lq, input logic [7:0] lr, input int llat);
    int lat;
    iv_b = 1; q_b = q; r_b = r; dz_b = z; or_b = 0;
    tick;
    q_b = ~q; r_b = ~r; dz_b = ~z;
    lat = 1;
    while (!ov_b && lat < 40) begin
      tick;
      lat++;
    end
    chk("b_valid_seen", 32'(ov_b), 32'd1);
    if (lit) begin
      chk("b_latency", 32'(lat), 32'(llat));
      chk("b_quo_lit", 32'(qb_b), 32'(lq));
      chk("b_rem_lit", 32'(rb_b), 32'(lr));
      chk("b_err_lit", 32'(err_b), 32'(z));
    end
    repeat (hold) tick;
    or_b = 1;
    tick;
    iv_b = 0; or_b = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    tick;
    tick;
    chk("a_reset_ready", 32'(ir_a), 32'd1);
    chk("a_reset_valid", 32'(ov_a), 32'd0);
    chk("b_reset_quo",   32'(qb_b), 32'd0);
    chk("b_reset_err",   32'(err_b), 32'd0);
    rst_a = 0; rst_b = 0;

    // Default widths: accept on the first edge after release, divide-by-zero, held DONE.
    xfer_a(3'd7, 2'd3, 1'b0, 0, 1, 4'h7, 4'h3, 4);
    xfer_a(3'd5, 2'd2, 1'b1, 0, 1, 4'hF, 4'hF, 1);
    xfer_a(3'd6, 2'd1, 1'b0, 5, 1, 4'h6, 4'h1, 4);
    for (int q = 0; q < 8; q++) begin
      for (int r = 0; r < 4; r++) begin
        xfer_a(3'(q), 2'(r), 1'b0, 0, 0, 4'h0, 4'h0, 0);
      end
    end

    // 8/4-bit instance.
    xfer_b(8'd255, 4'd9, 1'b0, 0, 1, 12'h255, 8'h09, 9);

    // Reset in the middle of a conversion.
    iv_b = 1; q_b = 8'd200; r_b = 4'd15; dz_b = 0;
    tick;
    iv_b = 0;
    tick;
    tick;
    #2;
    rst_b = 1;
    #1;
    chk("b_midrst_quo",   32'(qb_b),  32'd0);
    chk("b_midrst_rem",   32'(rb_b),  32'd0);
    chk("b_midrst_valid", 32'(ov_b),  32'd0);
    chk("b_midrst_ready", 32'(ir_b),  32'd1);
    tick;
    tick;
    rst_b = 0;
    repeat (12) tick;
    xfer_b(8'd100, 4'd0, 1'b0, 0, 1, 12'h100, 8'h00, 9);
    xfer_b(8'd37, 4'd4, 1'b1, 2, 1, 12'hFFF, 8'hFF, 1);
    xfer_b(8'd0, 4'd0, 1'b0, 0, 1, 12'h000, 8'h00, 9);
    xfer_b(8'd99, 4'd12, 1'b0, 3, 1, 12'h099, 8'h12, 9);
    xfer_b(8'd128, 4'd15, 1'b0, 0, 1, 12'h128, 8'h15, 9);
    repeat (3) tick;

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
